// File: rtl/regwb_pkg.sv
// rtl/regwb_pkg.sv - shared types and default sizes for the register writeback arbiter
package regwb_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_D     = 4;
    localparam int DEF_DEPTH = 2;

    typedef struct packed {
        logic [DEF_D-1:0] addr;
        logic [DEF_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - DEPTH-entry writeback queue exposing per-entry valid/addr for hazard compare
module wb_fifo
    import regwb_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int D     = DEF_D,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_valid,
    input  logic [D-1:0]       push_addr,
    input  logic [W-1:0]       push_data,
    output logic               push_ready,
    input  logic               pop,
    output logic               empty,
    output logic [D-1:0]       head_addr,
    output logic [W-1:0]       head_data,
    output logic [DEPTH-1:0]   entry_valid,
    output logic [DEPTH*D-1:0] entry_addr
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic [PW:0]  count;
    logic         full;
    logic         push;
    logic [D-1:0] addr_mem [DEPTH];
    logic [W-1:0] data_mem [DEPTH];

    // extra MSB on the pointers separates full from empty when the index bits match
    assign count      = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign push_ready = !full;
    assign push       = push_valid && !full;
    assign head_addr  = addr_mem[rd_ptr[PW-1:0]];
    assign head_data  = data_mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr[PW-1:0]] <= push_addr;
            data_mem[wr_ptr[PW-1:0]] <= push_data;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PW-1:0] offset;
        assign offset            = PW'(i) - rd_ptr[PW-1:0];
        assign entry_valid[i]    = ({1'b0, offset} < count);
        assign entry_addr[i*D +: D] = addr_mem[i];
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin ALU/load writeback arbiter for the register file write port
// Optional WB_FWD_EN adds in-flight forwarding outputs and drops the in-flight term from Hazard*.
module reg_write_arbiter
    import regwb_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int D     = DEF_D,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic         Clk,
    input  logic         ResetN,
    input  logic         AluValid,
    input  logic [D-1:0] AluAddr,
    input  logic [W-1:0] AluData,
    output logic         AluReady,
    input  logic         LdValid,
    input  logic [D-1:0] LdAddr,
    input  logic [W-1:0] LdData,
    output logic         LdReady,
    output logic         RfWriteEn,
    output logic [D-1:0] RfWaddr,
    output logic [W-1:0] RfDataIn,
`ifdef WB_FWD_EN
    output logic         FwdValidA,
    output logic         FwdValidB,
    output logic [W-1:0] FwdDataA,
    output logic [W-1:0] FwdDataB,
`endif
    input  logic [D-1:0] RaddrA,
    input  logic [D-1:0] RaddrB,
    output logic         HazardA,
    output logic         HazardB
);

    logic               alu_empty, ld_empty;
    logic [D-1:0]       alu_head_addr, ld_head_addr;
    logic [W-1:0]       alu_head_data, ld_head_data;
    logic [DEPTH-1:0]   alu_entry_valid, ld_entry_valid;
    logic [DEPTH*D-1:0] alu_entry_addr, ld_entry_addr;
    logic               grant_alu, grant_ld;
    wb_src_e            last_grant, next_grant;
    logic               queued_a, queued_b, inflight_a, inflight_b;

    wb_fifo #(.W(W), .D(D), .DEPTH(DEPTH)) u_alu_q (
        .clk(Clk), .rst_n(ResetN),
        .push_valid(AluValid), .push_addr(AluAddr), .push_data(AluData), .push_ready(AluReady),
        .pop(grant_alu), .empty(alu_empty), .head_addr(alu_head_addr), .head_data(alu_head_data),
        .entry_valid(alu_entry_valid), .entry_addr(alu_entry_addr)
    );

    wb_fifo #(.W(W), .D(D), .DEPTH(DEPTH)) u_ld_q (
        .clk(Clk), .rst_n(ResetN),
        .push_valid(LdValid), .push_addr(LdAddr), .push_data(LdData), .push_ready(LdReady),
        .pop(grant_ld), .empty(ld_empty), .head_addr(ld_head_addr), .head_data(ld_head_data),
        .entry_valid(ld_entry_valid), .entry_addr(ld_entry_addr)
    );

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            last_grant <= SRC_LD;
        end else begin
            last_grant <= next_grant;
        end
    end

    always_comb begin
        grant_alu  = 1'b0;
        grant_ld   = 1'b0;
        next_grant = last_grant;
        if (!alu_empty && !ld_empty) begin
            if (last_grant == SRC_LD) grant_alu = 1'b1;
            else                      grant_ld  = 1'b1;
        end else if (!alu_empty) begin
            grant_alu = 1'b1;
        end else if (!ld_empty) begin
            grant_ld = 1'b1;
        end
        if (grant_alu) next_grant = SRC_ALU;
        if (grant_ld)  next_grant = SRC_LD;
    end

    // address/data hold their last value on idle cycles; only the enable drops
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            RfWriteEn <= 1'b0;
            RfWaddr   <= '0;
            RfDataIn  <= '0;
        end else begin
            RfWriteEn <= grant_alu || grant_ld;
            if (grant_alu) begin
                RfWaddr  <= alu_head_addr;
                RfDataIn <= alu_head_data;
            end else if (grant_ld) begin
                RfWaddr  <= ld_head_addr;
                RfDataIn <= ld_head_data;
            end
        end
    end

    always_comb begin
        queued_a = 1'b0;
        queued_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_entry_valid[i] && alu_entry_addr[i*D +: D] == RaddrA) queued_a = 1'b1;
            if (ld_entry_valid[i]  && ld_entry_addr[i*D +: D]  == RaddrA) queued_a = 1'b1;
            if (alu_entry_valid[i] && alu_entry_addr[i*D +: D] == RaddrB) queued_b = 1'b1;
            if (ld_entry_valid[i]  && ld_entry_addr[i*D +: D]  == RaddrB) queued_b = 1'b1;
        end
    end

    assign inflight_a = RfWriteEn && (RfWaddr == RaddrA);
    assign inflight_b = RfWriteEn && (RfWaddr == RaddrB);

`ifdef WB_FWD_EN
    assign FwdValidA = inflight_a;
    assign FwdValidB = inflight_b;
    assign FwdDataA  = RfDataIn;
    assign FwdDataB  = RfDataIn;
    assign HazardA   = queued_a;
    assign HazardB   = queued_b;
`else
    assign HazardA   = queued_a || inflight_a;
    assign HazardB   = queued_b || inflight_b;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed table-driven bench for reg_write_arbiter
module tb_reg_write_arbiter;

    logic       Clk;
    logic       ResetN;
    logic       AluValid, LdValid;
    logic [3:0] AluAddr, LdAddr;
    logic [7:0] AluData, LdData;
    logic       AluReady, LdReady;
    logic       RfWriteEn;
    logic [3:0] RfWaddr;
    logic [7:0] RfDataIn;
    logic [3:0] RaddrA, RaddrB;
    logic       HazardA, HazardB;
`ifdef WB_FWD_EN
    logic       FwdValidA, FwdValidB;
    logic [7:0] FwdDataA, FwdDataB;
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    reg_write_arbiter #(.W(8), .D(4), .DEPTH(2)) dut (
        .Clk(Clk), .ResetN(ResetN),
        .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData), .AluReady(AluReady),
        .LdValid(LdValid), .LdAddr(LdAddr), .LdData(LdData), .LdReady(LdReady),
        .RfWriteEn(RfWriteEn), .RfWaddr(RfWaddr), .RfDataIn(RfDataIn),
`ifdef WB_FWD_EN
        .FwdValidA(FwdValidA), .FwdValidB(FwdValidB), .FwdDataA(FwdDataA), .FwdDataB(FwdDataB),
`endif
        .RaddrA(RaddrA), .RaddrB(RaddrB), .HazardA(HazardA), .HazardB(HazardB)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst;
        logic       av;
        logic [3:0] aa;
        logic [7:0] ad;
        logic       lv;
        logic [3:0] la;
        logic [7:0] ldd;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic       ardy;
        logic       lrdy;
        logic       ha;
        logic       hb;
        logic       fa;
        logic       fb;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic row(input int rst, input int av, input int aa, input int ad,
                       input int lv, input int la, input int ldd, input int ra, input int rb,
                       input int we, input int wa, input int wd, input int ardy, input int lrdy,
                       input int ha, input int hb, input int fa, input int fb);
        vec_t v;
        v.rst = 1'(rst); v.av = 1'(av); v.aa = 4'(aa); v.ad = 8'(ad);
        v.lv = 1'(lv); v.la = 4'(la); v.ldd = 8'(ldd); v.ra = 4'(ra); v.rb = 4'(rb);
        v.we = 1'(we); v.wa = 4'(wa); v.wd = 8'(wd); v.ardy = 1'(ardy); v.lrdy = 1'(lrdy);
        v.ha = 1'(ha); v.hb = 1'(hb); v.fa = 1'(fa); v.fb = 1'(fb);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        ResetN = 1'b0;
        AluValid = 1'b0; AluAddr = '0; AluData = '0;
        LdValid = 1'b0; LdAddr = '0; LdData = '0;
        RaddrA = '0; RaddrB = '0;

        // single ALU write, then idle hold
        row(1, 0,0,'h00, 0,0,'h00, 0,0, 0,0,'h00, 1,1, 0,0, 0,0);
        row(0, 1,3,'h5A, 0,0,'h00, 3,0, 0,0,'h00, 1,1, 0,0, 0,0);
        row(0, 0,0,'h00, 0,0,'h00, 3,0, 0,0,'h00, 1,1, 1,0, 0,0);
        row(0, 0,0,'h00, 0,0,'h00, 3,0, 1,3,'h5A, 1,1, 1,0, 1,0);
        row(0, 0,0,'h00, 0,0,'h00, 3,0, 0,3,'h5A, 1,1, 0,0, 0,0);
        row(0, 0,0,'h00, 0,0,'h00, 3,0, 0,3,'h5A, 1,1, 0,0, 0,0);
        // both sources saturated: ALU odd addrs, LD even addrs, alternating grants
        row(1, 0,0,'h00, 0,0,'h00, 0,0, 0,0,'h00, 1,1, 0,0, 0,0);
        row(0, 1,1,'hA1, 1,2,'hB2, 8,1, 0,0,'h00, 1,1, 0,0, 0,0);
        row(0, 1,3,'hA3, 1,4,'hB4, 8,1, 0,0,'h00, 1,1, 0,1, 0,0);
        row(0, 1,5,'hA5, 1,6,'hB6, 8,1, 1,1,'hA1, 1,0, 0,1, 0,1);
        row(0, 1,7,'hA7, 1,6,'hB6, 8,1, 1,2,'hB2, 0,1, 0,0, 0,0);
        row(0, 1,7,'hA7, 1,8,'hB8, 8,1, 1,3,'hA3, 1,0, 0,0, 0,0);
        row(0, 0,0,'h00, 1,8,'hB8, 8,1, 1,4,'hB4, 0,1, 0,0, 0,0);
        row(0, 0,0,'h00, 0,0,'h00, 8,1, 1,5,'hA5, 1,0, 1,0, 0,0);
        row(0, 0,0,'h00, 0,0,'h00, 8,1, 1,6,'hB6, 1,1, 1,0, 0,0);
        row(0, 0,0,'h00, 0,0,'h00, 8,1, 1,7,'hA7, 1,1, 1,0, 0,0);
        row(0, 0,0,'h00, 0,0,'h00, 8,1, 1,8,'hB8, 1,1, 1,0, 1,0);
        row(0, 0,0,'h00, 0,0,'h00, 8,1, 0,8,'hB8, 1,1, 0,0, 0,0);
        // LD held valid 3 cycles against a saturated ALU; reg 14 push is refused while full
        row(1, 0,0,'h00, 0,0,'h00, 0,0, 0,0,'h00, 1,1, 0,0, 0,0);
        row(0, 1,9,'hC9, 1,10,'hDA, 14,12, 0,0,'h00, 1,1, 0,0, 0,0);
        row(0, 1,11,'hCB, 1,12,'hDC, 14,12, 0,0,'h00, 1,1, 0,0, 0,0);
        row(0, 1,13,'hCD, 1,14,'hDE, 14,12, 1,9,'hC9, 1,0, 0,1, 0,0);
        row(0, 1,15,'hCF, 0,0,'h00, 14,12, 1,10,'hDA, 0,1, 0,1, 0,0);
        row(0, 1,15,'hCF, 0,0,'h00, 14,12, 1,11,'hCB, 1,1, 0,1, 0,0);
        row(0, 0,0,'h00, 0,0,'h00, 14,12, 1,12,'hDC, 0,1, 0,1, 0,1);
        row(0, 0,0,'h00, 0,0,'h00, 14,12, 1,13,'hCD, 1,1, 0,0, 0,0);
        row(0, 0,0,'h00, 0,0,'h00, 14,12, 1,15,'hCF, 1,1, 0,0, 0,0);
        row(0, 0,0,'h00, 0,0,'h00, 14,12, 0,15,'hCF, 1,1, 0,0, 0,0);
        // LD write to reg 5 watched on RaddrA
        row(0, 0,0,'h00, 1,5,'h3C, 5,0, 0,15,'hCF, 1,1, 0,0, 0,0);
        row(0, 0,0,'h00, 0,0,'h00, 5,0, 0,15,'hCF, 1,1, 1,0, 0,0);
        row(0, 0,0,'h00, 0,0,'h00, 5,0, 1,5,'h3C, 1,1, 1,0, 1,0);
        row(0, 0,0,'h00, 0,0,'h00, 5,0, 0,5,'h3C, 1,1, 0,0, 0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            logic exp_ha, exp_hb;
            @(negedge Clk);
            ResetN   = !vecs[i].rst;
            AluValid = vecs[i].av;  AluAddr = vecs[i].aa; AluData = vecs[i].ad;
            LdValid  = vecs[i].lv;  LdAddr  = vecs[i].la; LdData  = vecs[i].ldd;
            RaddrA   = vecs[i].ra;  RaddrB  = vecs[i].rb;
            #1;
            exp_ha = FWD ? (vecs[i].ha && !vecs[i].fa) : vecs[i].ha;
            exp_hb = FWD ? (vecs[i].hb && !vecs[i].fb) : vecs[i].hb;
            chk($sformatf("row%0d_we", i),   32'(RfWriteEn), 32'(vecs[i].we));
            chk($sformatf("row%0d_waddr", i), 32'(RfWaddr),  32'(vecs[i].wa));
            chk($sformatf("row%0d_data", i),  32'(RfDataIn), 32'(vecs[i].wd));
            chk($sformatf("row%0d_alu_rdy", i), 32'(AluReady), 32'(vecs[i].ardy));
            chk($sformatf("row%0d_ld_rdy", i),  32'(LdReady),  32'(vecs[i].lrdy));
            chk($sformatf("row%0d_haz_a", i), 32'(HazardA), 32'(exp_ha));
            chk($sformatf("row%0d_haz_b", i), 32'(HazardB), 32'(exp_hb));
`ifdef WB_FWD_EN
            chk($sformatf("row%0d_fwd_a", i), 32'(FwdValidA), 32'(vecs[i].fa));
            chk($sformatf("row%0d_fwd_b", i), 32'(FwdValidB), 32'(vecs[i].fb));
            if (vecs[i].fa) chk($sformatf("row%0d_fwd_data_a", i), 32'(FwdDataA), 32'(vecs[i].wd));
            if (vecs[i].fb) chk($sformatf("row%0d_fwd_data_b", i), 32'(FwdDataB), 32'(vecs[i].wd));
`endif
        end

        // asynchronous reset in the middle of a burst
        @(negedge Clk);
        ResetN = 1'b1;
        AluValid = 1'b1; AluAddr = 4'd2; AluData = 8'h11;
        LdValid  = 1'b1; LdAddr  = 4'd4; LdData  = 8'h22;
        RaddrA = 4'd2; RaddrB = 4'd4;
        repeat (3) @(posedge Clk);
        #2;
        chk("burst_we_before_reset", 32'(RfWriteEn), 32'd1);
        chk("burst_haz_a_before_reset", 32'(HazardA), 32'd1);
        ResetN = 1'b0;
        #1;
        chk("async_reset_we", 32'(RfWriteEn), 32'd0);
        chk("async_reset_haz_a", 32'(HazardA), 32'd0);
        chk("async_reset_haz_b", 32'(HazardB), 32'd0);
        chk("async_reset_alu_rdy", 32'(AluReady), 32'd1);
        chk("async_reset_ld_rdy", 32'(LdReady), 32'd1);
        AluValid = 1'b0; LdValid = 1'b0;
        @(negedge Clk);
        ResetN = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            chk($sformatf("post_reset_we_%0d", c), 32'(RfWriteEn), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
